nibble_serial_add_ctrl: RTL and testbench
=========================================

# nibble_serial_add_ctrl

Sequencer that drives an external 4-bit adder slice one nibble per clock to add two WIDTH-bit operands, carrying between nibbles through a registered carry. Sits directly upstream of the 4-bit slice, feeding its a/b/c_in and consuming its s/c_out. Assembles the full-width sum, carry-out and signed overflow, and reports completion with a done pulse. Used where a single small adder slice must serve wide additions from switch/register inputs.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4.
- Clk  input  1  system clock; the only clock in the block.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- c_in  input  1  carry into nibble 0; sampled with start.
- operand_a  input  WIDTH  addend A; sampled with start.
- operand_b  input  WIDTH  addend B; sampled with start.
- accum  input  1  present only with NIBBLE_ACCUM_EN; see Configuration.
- slice_a  output  4  A nibble to adder slice.
- slice_b  output  4  B nibble to adder slice.
- slice_cin  output  1  carry to adder slice.
- slice_s  input  4  slice sum, combinational from slice_a/b/cin.
- slice_cout  input  1  slice carry-out.
- busy  output  1  high in ADD.
- done  output  1  one-cycle pulse in DONE.
- sum  output  WIDTH  registered result.
- c_out  output  1  registered final carry.
- ovf  output  1  registered two's-complement overflow.

## Operation
- States: IDLE, ADD, DONE.
- IDLE: start=1 → load A/B shift registers from operands, carry reg ← c_in, nibble counter ← 0, latch MSBs of A and B; go ADD. start=0 → stay.
- ADD: slice_a = A_sh[3:0], slice_b = B_sh[3:0], slice_cin = carry reg. Each edge: A_sh, B_sh shift right 4; slice_s shifted into top nibble of sum shift register; carry reg ← slice_cout; counter++. After the NIB-th ADD cycle (counter = NIB-1) go DONE.
- Entering DONE: sum ← assembled sum shift register, c_out ← final slice_cout, ovf ← (A_msb == B_msb) && (sum[WIDTH-1] != A_msb).
- DONE: done=1 for exactly one cycle; unconditionally → IDLE.
- start in ADD or DONE ignored; no queueing. start held high in IDLE re-triggers a new add each time IDLE is reached.
- Outside ADD, slice_a, slice_b, slice_cin are driven 0.
- sum, c_out, ovf hold their values until the next DONE entry; never show partial results.
- Arithmetic modulo 2^WIDTH; carry out of the top nibble goes to c_out only.

## Timing
- Reset (Reset=1 at an edge): state IDLE, counter 0, carry reg 0, all shift registers 0, sum 0, c_out 0, ovf 0, busy 0, done 0, slice outputs 0. Reset overrides start on the same edge.
- Reset mid-ADD: operation abandoned, no done pulse, sum/c_out/ovf cleared to 0.
- start sampled at edge E: busy=1 in cycles E+1 … E+NIB; done=1 and new sum/c_out/ovf visible in cycle E+NIB+1; block back in IDLE at E+NIB+2 (next start accepted at that edge).
- Throughput: one add per NIB+2 cycles with start held high.
- Slice is combinational in the same cycle; no slice pipelining allowed.

## Configuration
- NIBBLE_ACCUM_EN defined: accum port exists; when start=1 and accum=1 in IDLE, A shift register loads from current sum register instead of operand_a (and A_msb from sum[WIDTH-1]); accum=0 behaves as normal.
- NIBBLE_ACCUM_EN undefined: no accum port; A always loads from operand_a.

## Test plan
- Reset, then start with A=0x1234, B=0x4321, c_in=0 → busy 4 cycles, done in cycle E+5, sum=0x5555, c_out=0, ovf=0.
- A=0xFFFF, B=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0; slice_cin=1 observed on nibbles 1–3.
- A=0x7FFF, B=0x0001 → sum=0x8000, c_out=0, ovf=1; A=0x0000, B=0x0000, c_in=1 → sum=0x0001.
- Pulse start again during ADD with different operands → ignored, first result delivered unchanged, single done pulse.
- Assert Reset in 2nd ADD cycle → next cycle IDLE, busy=0, sum=0, no done pulse; following add completes normally.
- NIBBLE_ACCUM_EN: add 0x0003+0x0000 → sum=0x0003; then start accum=1, B=0x0004 → sum=0x0007, c_out=0.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: drives an external 4-bit adder slice one nibble per clock.
// Optional accumulate mode (A loads from the previous sum) is enabled with NIBBLE_ACCUM_EN.
module nibble_serial_add_ctrl #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             c_in_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
`ifdef NIBBLE_ACCUM_EN
  input  logic             accum_i,
`endif
  output logic [3:0]       slice_a_o,
  output logic [3:0]       slice_b_o,
  output logic             slice_cin_o,
  input  logic [3:0]       slice_s_i,
  input  logic             slice_cout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] sum_o,
  output logic             c_out_o,
  output logic             ovf_o
);

  localparam int unsigned Nib  = Width / 4;
  localparam int unsigned CntW = (Nib > 1) ? $clog2(Nib) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Nib - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [Width-1:0] a_sh_q, a_sh_d;
  logic [Width-1:0] b_sh_q, b_sh_d;
  logic [Width-1:0] sum_sh_q, sum_sh_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [Width-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [Width+3:0] sum_cat;
  logic [Width-1:0] load_a;

  assign sum_cat = {slice_s_i, sum_sh_q};

`ifdef NIBBLE_ACCUM_EN
  assign load_a = accum_i ? sum_q : operand_a_i;
`else
  assign load_a = operand_a_i;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    slice_a_o   = 4'h0;
    slice_b_o   = 4'h0;
    slice_cin_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_sh_d  = load_a;
          b_sh_d  = operand_b_i;
          carry_d = c_in_i;
          cnt_d   = '0;
          a_msb_d = load_a[Width-1];
          b_msb_d = operand_b_i[Width-1];
          state_d = StAdd;
        end
      end
      StAdd: begin
        busy_o      = 1'b1;
        slice_a_o   = a_sh_q[3:0];
        slice_b_o   = b_sh_q[3:0];
        slice_cin_o = carry_q;
        a_sh_d      = a_sh_q >> 4;
        b_sh_d      = b_sh_q >> 4;
        sum_sh_d    = sum_cat[Width+3:4];
        carry_d     = slice_cout_i;
        cnt_d       = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // Final nibble: publish the fully assembled result in one step.
          state_d = StDone;
          sum_d   = sum_sh_d;
          c_out_d = slice_cout_i;
          ovf_d   = (a_msb_q == b_msb_q) && (sum_sh_d[Width-1] != a_msb_q);
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum_o   = sum_q;
  assign c_out_o = c_out_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: behavioural 4-bit slice, whole-word arithmetic reference,
// directed corner cases plus randomized adds (accumulate cases when NIBBLE_ACCUM_EN is defined).
module tb_nibble_serial_add_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         c_in;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         accum;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_s;
  logic         slice_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Expected contents of the result registers.
  logic [W-1:0] exp_sum   = '0;
  logic         exp_c_out = 1'b0;
  logic         exp_ovf   = 1'b0;

  always #5 clk = ~clk;

  assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

  nibble_serial_add_ctrl #(.Width(W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .c_in_i       (c_in),
    .operand_a_i  (op_a),
    .operand_b_i  (op_b),
`ifdef NIBBLE_ACCUM_EN
    .accum_i      (accum),
`endif
    .slice_a_o    (slice_a),
    .slice_b_o    (slice_b),
    .slice_cin_o  (slice_cin),
    .slice_s_i    (slice_s),
    .slice_cout_i (slice_cout),
    .busy_o       (busy),
    .done_o       (done),
    .sum_o        (sum),
    .c_out_o      (c_out),
    .ovf_o        (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(c_out), 64'(exp_c_out));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
  endtask

  // One full add; returns at the negedge of the first IDLE cycle after DONE.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic acc, input logic inject);
    logic [W-1:0] ea;
    logic [W:0]   full;
    logic [W:0]   lo;
    logic [W:0]   m;
    ea   = acc ? exp_sum : a;
    full = {1'b0, ea} + {1'b0, b} + {{W{1'b0}}, cin};
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; c_in = cin; accum = acc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); c_in = 1'($urandom); accum = 1'b0;
    for (int k = 0; k < NIB; k++) begin
      if (inject && k == 1) begin
        start = 1'b1; op_a = W'($urandom); op_b = W'($urandom); c_in = 1'b1;
      end
      if (inject && k == 2) start = 1'b0;
      m  = ((W+1)'(1) << (4 * k)) - 1'b1;
      lo = ({1'b0, ea} & m) + ({1'b0, b} & m) + {{W{1'b0}}, cin};
      check("add_busy", 64'(busy), 64'd1);
      check("add_done_low", 64'(done), 64'd0);
      check("slice_a", 64'(slice_a), 64'((ea >> (4 * k)) & 16'hF));
      check("slice_b", 64'(slice_b), 64'((b >> (4 * k)) & 16'hF));
      check("slice_cin", 64'(slice_cin), 64'(lo[4 * k]));
      check("sum_held", 64'(sum), 64'(exp_sum));
      @(negedge clk);
    end
    exp_sum   = full[W-1:0];
    exp_c_out = full[W];
    exp_ovf   = (ea[W-1] == b[W-1]) && (full[W-1] != ea[W-1]);
    check("done_pulse", 64'(done), 64'd1);
    check("done_busy_low", 64'(busy), 64'd0);
    check("done_slice_a_zero", 64'(slice_a), 64'd0);
    check_results("done");
    @(negedge clk);
    check("idle_done_low", 64'(done), 64'd0);
    check("idle_busy_low", 64'(busy), 64'd0);
    check_results("idle");
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; c_in = 1'b0; op_a = '0; op_b = '0; accum = 1'b0;
    @(posedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_slice", 64'({slice_a, slice_b, slice_cin}), 64'd0);
    check_results("rst");
    start = 1'b0; reset = 1'b0;

    run_add(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_add(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_add(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_add(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    run_add(16'hA5A5, 16'h1111, 1'b1, 1'b0, 1'b1);

    // Reset in the second ADD cycle abandons the add.
    @(negedge clk);
    start = 1'b1; op_a = 16'h0F0F; op_b = 16'h0101; c_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_sum = '0; exp_c_out = 1'b0; exp_ovf = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check_results("rst_mid");
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", 64'(done), 64'd0);
    end
    run_add(16'h1357, 16'h2468, 1'b0, 1'b0, 1'b0);

    // Start held high re-arms every NIB+2 cycles.
    @(negedge clk);
    start = 1'b1; op_a = 16'h0100; op_b = 16'h0023; c_in = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_first_done", 64'(done), 64'd1);
    n = 1;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("held_period", 64'(n), 64'(NIB + 2));
    exp_sum = 16'h0124; exp_c_out = 1'b0; exp_ovf = 1'b0;
    check_results("held");
    @(negedge clk);
    @(negedge clk);
    check("held_stop_busy", 64'(busy), 64'd0);

`ifdef NIBBLE_ACCUM_EN
    run_add(16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_add(16'hDEAD, 16'h0004, 1'b0, 1'b1, 1'b0);
    check("accum_sum", 64'(sum), 64'h0007);
    for (int i = 0; i < 6; i++)
      run_add(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
`endif

    for (int i = 0; i < 20; i++)
      run_add(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'($urandom_range(0, 3) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
